// File: rtl/uart_loader_pkg.sv
// uart_loader_pkg: shared state encoding, error codes and word helpers for the UART loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BREAK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

    function automatic logic [63:0] all_ones(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/uart_imem_loader_asm.sv
// uart_word_assembler: fills a word little-endian from UART bytes and watches the inter-byte gap.
module uart_word_assembler
    import uart_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] word,
    output logic              complete,
    output logic              timeout
);
    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [DATA_W-1:0] fill;
    logic [BW-1:0]     byte_idx;
    logic [TW-1:0]     tcnt;

    // word is the fill register with the incoming byte already merged into its lane
    always_comb begin
        word = fill;
        word[byte_idx*8 +: 8] = rx_data;
    end

    assign complete = accept && byte_idx == BW'(NB - 1);
    assign timeout  = !clear && !accept && byte_idx != '0 && tcnt == TW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            fill     <= '0;
            byte_idx <= '0;
            tcnt     <= '0;
        end else if (accept) begin
            fill     <= word;
            byte_idx <= complete ? '0 : byte_idx + 1'b1;
            tcnt     <= '0;
        end else if (byte_idx != '0) begin
            tcnt <= tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: loads instruction words received over UART into memory until a terminator run.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int TERM_COUNT  = 2,
    parameter int TIMEOUT_CYC = 100000,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              restart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              write_done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);
    localparam int RUN_W = $clog2(TERM_COUNT + 1);
    localparam logic [DATA_W-1:0] ONES = DATA_W'(all_ones(DATA_W));

    state_t            state, nxt;
    logic [1:0]        nerr;
    logic [RUN_W-1:0]  run;
    logic [ADDR_W:0]   wc_eff;
    logic [DATA_W-1:0] word;
    logic              collecting, accept, start, complete, timeout;
    logic              term_hit, overflow, do_write;

    assign collecting = state == S_COLLECT;
    assign accept     = collecting && rx_valid && !rx_break;
    assign start      = (state == S_IDLE && load_en) ||
                        ((state == S_DONE || state == S_ERR) && restart);
    // count including a write still in flight, so a word completing on the mem_we cycle sees it
    assign wc_eff     = word_count + (ADDR_W + 1)'(mem_we);
    assign term_hit   = mem_we && mem_wdata == ONES && run == RUN_W'(TERM_COUNT - 1);
    assign overflow   = complete && wc_eff == (ADDR_W + 1)'(DEPTH);
    assign do_write   = complete && nxt == S_COLLECT;

    uart_word_assembler #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (!collecting),
        .accept   (accept),
        .rx_data  (rx_data),
        .word     (word),
        .complete (complete),
        .timeout  (timeout)
    );

    always_comb begin
        nxt  = state;
        nerr = err_code;
        if (start) begin
            nxt  = S_COLLECT;
            nerr = ERR_NONE;
        end else if (collecting) begin
            if (rx_break) begin
                nxt  = S_ERR;
                nerr = ERR_BREAK;
            end else if (term_hit) begin
                nxt = S_DONE;
            end else if (overflow) begin
                nxt  = S_ERR;
                nerr = ERR_OVERFLOW;
            end else if (timeout) begin
                nxt  = S_ERR;
                nerr = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            write_done <= 1'b0;
            err_code   <= ERR_NONE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            run        <= '0;
        end else begin
            state      <= nxt;
            busy       <= nxt == S_COLLECT;
            write_done <= nxt == S_DONE;
            err_code   <= nerr;
            mem_we     <= do_write;
            if (do_write) begin
                mem_addr  <= wc_eff[ADDR_W-1:0];
                mem_wdata <= word;
            end
            if (start) begin
                mem_addr   <= '0;
                word_count <= '0;
                run        <= '0;
            end else if (mem_we) begin
                word_count <= word_count + 1'b1;
                run        <= (mem_wdata == ONES) ? run + 1'b1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb_uart_imem_loader: directed and randomized loads checked against a word-level reference model.
module tb_uart_imem_loader;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int TC = 2;
    localparam int TO = 50;
    localparam int AW = 2;

    logic clk = 1'b0, rst = 1'b1, load_en = 1'b0, restart = 1'b0;
    logic rx_valid = 1'b0, rx_break = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic mem_we, busy, write_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0] err_code;
    logic [AW:0] word_count;

    uart_imem_loader #(.DATA_W(DW), .DEPTH(DEPTH), .TERM_COUNT(TC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .restart(restart),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .write_done(write_done), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t wq[$];
    wr_t mon_w;
    int dq[$];
    logic wd_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            mon_w.cyc = cyc;
            mon_w.addr = mem_addr;
            mon_w.data = mem_wdata;
            wq.push_back(mon_w);
        end
        if (write_done && !wd_prev) dq.push_back(cyc);
        wd_prev <= write_done;
    end

    int compared = 0, mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: bytes grouped into little-endian words, written until terminator run or full
    logic [DW-1:0] ew_data[$];
    int ew_addr[$];
    int e_end, e_err, e_wc;

    task automatic model(input logic [7:0] b[$]);
        int run = 0;
        logic [31:0] w;
        ew_data.delete();
        ew_addr.delete();
        e_end = 0;
        e_err = 0;
        e_wc = 0;
        for (int i = 0; i + 4 <= b.size() && e_end == 0; i += 4) begin
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            if (e_wc == DEPTH) begin
                e_end = 2;
                e_err = 3;
            end else begin
                ew_addr.push_back(e_wc);
                ew_data.push_back(w);
                e_wc++;
                run = (w == 32'hFFFF_FFFF) ? run + 1 : 0;
                if (run == TC) e_end = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic put_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) put(w[i*8 +: 8], 0);
    endtask

    task automatic pulse_load();
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    logic [7:0] bq[$];

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) bq.push_back(w[i*8 +: 8]);
    endtask

    task automatic run_load(input string tag, input logic [7:0] b[$], input logic use_restart);
        int base = wq.size();
        int dbase = dq.size();
        model(b);
        if (use_restart) pulse_restart();
        else pulse_load();
        for (int i = 0; i < b.size(); i++) put(b[i], $urandom_range(0, 3));
        idle(6);
        check({tag, " nwr"}, 64'(wq.size() - base), 64'(ew_data.size()));
        for (int i = 0; i < ew_data.size() && base + i < wq.size(); i++) begin
            check({tag, " addr"}, 64'(wq[base+i].addr), 64'(ew_addr[i]));
            check({tag, " data"}, 64'(wq[base+i].data), 64'(ew_data[i]));
        end
        check({tag, " write_done"}, 64'(write_done), 64'(e_end == 1));
        check({tag, " err_code"}, 64'(err_code), 64'(e_err));
        check({tag, " busy"}, 64'(busy), 64'(e_end == 0));
        check({tag, " word_count"}, 64'(word_count), 64'(e_wc));
        if (e_end == 1 && wq.size() > base)
            check({tag, " done_lat"}, 64'(dq.size() > dbase ? dq[dbase] : -1),
                  64'(wq[wq.size()-1].cyc + 1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " mem_we"}, 64'(mem_we), 64'(0));
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " write_done"}, 64'(write_done), 64'(0));
        check({tag, " err_code"}, 64'(err_code), 64'(0));
        check({tag, " word_count"}, 64'(word_count), 64'(0));
    endtask

    initial begin
        int base;
        int n;
        logic [31:0] w;

        @(negedge clk);
        idle(2);
        check_reset_values("reset");
        rst = 1'b0;
        idle(1);

        // first program word followed by two terminator words
        bq.delete();
        base = wq.size();
        bq = '{8'h13, 8'h01, 8'h01, 8'hFD};
        for (int i = 0; i < 8; i++) bq.push_back(8'hFF);
        run_load("basic", bq, 1'b0);
        check("basic word0", 64'(wq.size() > base ? wq[base].data : '0), 64'h0000_0000_FD01_0113);

        bq.delete();
        add_word(32'hFFFF_FFFF);
        add_word(32'h0000_0000);
        add_word(32'hFFFF_FFFF);
        add_word(32'hFFFF_FFFF);
        run_load("term_reset", bq, 1'b1);

        for (int it = 0; it < 8; it++) begin
            bq.delete();
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++)
                add_word(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
            add_word(32'hFFFF_FFFF);
            add_word(32'hFFFF_FFFF);
            run_load("random", bq, 1'b1);
        end

        bq.delete();
        for (int k = 0; k < 5; k++) add_word($urandom & 32'h7FFF_FFFF);
        run_load("overflow", bq, 1'b1);

        // timeout: partial word left waiting past the inter-byte limit
        base = wq.size();
        pulse_restart();
        put(8'h11, 0);
        put(8'h22, 0);
        idle(44);
        check("timeout early busy", 64'(busy), 64'(1));
        check("timeout early err", 64'(err_code), 64'(0));
        idle(8);
        check("timeout err", 64'(err_code), 64'(2));
        check("timeout busy", 64'(busy), 64'(0));
        check("timeout done", 64'(write_done), 64'(0));
        check("timeout nwr", 64'(wq.size() - base), 64'(0));
        pulse_restart();
        w = $urandom;
        put_word(w);
        idle(3);
        check("timeout restart nwr", 64'(wq.size() - base), 64'(1));
        check("timeout restart addr", 64'(wq.size() > base ? wq[base].addr : 2'd3), 64'(0));
        check("timeout restart data", 64'(wq.size() > base ? wq[base].data : ~w), 64'(w));
        check("timeout restart busy", 64'(busy), 64'(1));

        // break alone, then break coincident with the third byte
        rx_break = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        idle(1);
        check("break err", 64'(err_code), 64'(1));
        base = wq.size();
        pulse_restart();
        put(8'hA1, 1);
        put(8'hA2, 0);
        rx_valid = 1'b1;
        rx_break = 1'b1;
        rx_data = 8'hA3;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_break = 1'b0;
        idle(5);
        check("break3 err", 64'(err_code), 64'(1));
        check("break3 busy", 64'(busy), 64'(0));
        pulse_load();
        put_word($urandom);
        idle(3);
        check("break load_en ignored busy", 64'(busy), 64'(0));
        check("break load_en ignored err", 64'(err_code), 64'(1));
        check("break nwr", 64'(wq.size() - base), 64'(0));
        pulse_restart();
        w = $urandom;
        put_word(w);
        idle(3);
        check("break restart data", 64'(wq.size() > base ? wq[base].data : ~w), 64'(w));
        check("break restart wc", 64'(word_count), 64'(1));

        // asynchronous reset in the middle of a word
        put(8'h55, 0);
        put(8'h66, 1);
        rst = 1'b1;
        #1;
        check_reset_values("rst mid");
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        base = wq.size();
        pulse_load();
        w = $urandom;
        put_word(w);
        idle(3);
        check("rst mid nwr", 64'(wq.size() - base), 64'(1));
        check("rst mid addr", 64'(wq.size() > base ? wq[base].addr : 2'd3), 64'(0));
        check("rst mid data", 64'(wq.size() > base ? wq[base].data : ~w), 64'(w));

        // asynchronous reset landing on a mem_we cycle
        put_word($urandom);
        check("rst we pre", 64'(mem_we), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_values("rst we");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_imem_loader.md
UART_IMEM_LOADER -- requirements
Module: uart_imem_loader

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits, a multiple of 8, range 8..64.
REQ-002 Parameter DEPTH, default 64: number of memory words; ADDR_W = clog2(DEPTH).
REQ-003 Parameter TERM_COUNT, default 2: number of consecutive all-ones words that ends a load.
REQ-004 Parameter TIMEOUT_CYC, default 100000: clock cycles allowed between bytes inside one word.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 load_en  in  1  arms the loader from IDLE.
REQ-008 restart  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
REQ-009 rx_valid  in  1  single-cycle strobe; rx_data holds a received byte.
REQ-010 rx_data  in  8  received UART byte.
REQ-011 rx_break  in  1  single-cycle strobe; UART BREAK detected.
REQ-012 mem_we  out  1  one-cycle memory write strobe.
REQ-013 mem_addr  out  ADDR_W  word address for mem_we.
REQ-014 mem_wdata  out  DATA_W  assembled word for mem_we.
REQ-015 busy  out  1  high in COLLECT.
REQ-016 write_done  out  1  high in DONE.
REQ-017 err_code  out  2  00 none, 01 break, 10 timeout, 11 overflow; valid in ERR.
REQ-018 word_count  out  ADDR_W+1  number of words written in the current load.

Function
REQ-019 FSM states: IDLE, COLLECT, DONE, ERR.
REQ-020 IDLE->COLLECT when load_en=1; DONE/ERR->COLLECT on restart. Entering COLLECT clears byte index, address, word_count, terminator run, timeout counter and err_code.
REQ-021 In COLLECT, each rx_valid byte fills byte lane byte_idx, little-endian: the first byte goes to bits [7:0].
REQ-022 Word completes on byte DATA_W/8; mem_we pulses exactly one cycle after the completing rx_valid, with mem_addr = word_count and mem_wdata = the assembled word.
REQ-023 word_count and the address increment on the mem_we cycle; byte_idx returns to 0 on the completing byte, so the next byte may arrive in the mem_we cycle without loss.
REQ-024 Every completed word is written, including all-ones words.
REQ-025 Terminator run: increments on each all-ones word written and clears on any other word. Reaching TERM_COUNT moves the FSM to DONE on the cycle after that mem_we.
REQ-026 Overflow: a word completing when word_count = DEPTH is not written; the FSM goes to ERR with code 11.
REQ-027 rx_break in COLLECT moves the FSM to ERR with code 01. If rx_break and rx_valid coincide, break wins and the byte is discarded.
REQ-028 Timeout: the counter runs only while byte_idx != 0 and clears on each accepted byte. Reaching TIMEOUT_CYC moves the FSM to ERR with code 10 and discards the partial word.
REQ-029 rx_valid, rx_break and load_en are ignored in IDLE, DONE and ERR. restart is ignored in IDLE and COLLECT.
REQ-030 mem_we never asserts outside COLLECT and the cycle immediately following it; at most one write per word.
REQ-031 busy, write_done and err_code are registered outputs derived from state, with no combinational path from inputs.

Reset
REQ-032 rst forces IDLE asynchronously, including in the middle of a word or on a mem_we cycle; the partial word is discarded.
REQ-033 Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, write_done=0, err_code=00, word_count=0; internal counters cleared.

Structure
REQ-034 Shared package uart_loader_pkg holds: the state enum, the err_code constants, and a function returning an all-ones word of DATA_W.
REQ-035 One sub-module, uart_word_assembler, holds the byte-lane shift/fill register, byte_idx, the timeout counter and the word-complete strobe. The FSM, address and terminator logic stay in the top module.

Verification
REQ-036 DATA_W=32: load_en; bytes 13,01,01,FD, then FF x8 -> mem_we at addr0 with FD010113, addr1 FFFFFFFF, addr2 FFFFFFFF; write_done one cycle later; word_count=3.
REQ-037 Bytes FF x4, 00 x4, FF x8 -> 4 writes; terminator run resets on word 00000000; DONE only after the 4th write.
REQ-038 TIMEOUT_CYC=50: bytes 11,22 then 50 idle cycles -> ERR with err_code=10 and no mem_we; then restart and 4 bytes -> write at addr 0.
REQ-039 rx_break coincident with the 3rd byte -> ERR with err_code=01, no write; load_en ignored until restart.
REQ-040 DEPTH=4: 5 non-terminator words -> 4 writes at addr 0..3; 5th word gives ERR with err_code=11; word_count=4.
REQ-041 rst asserted between bytes 2 and 3 -> all outputs at reset values immediately; after load_en, new bytes start at lane 0 and addr 0.
